// File: rtl/imem_responder.sv
// Fixed-latency instruction memory responder with a preload port and a sticky range-error flag.
// Define IMEM_STATS_EN to add the req_count / abort_count statistics outputs.
module imem_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 3,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_req_valid,
    input  logic [31:0]                  mem_req_addr,
    output logic                         mem_req_ready,
    output logic [31:0]                  mem_req_rdata,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    output logic                         addr_err
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]                  req_count,
    output logic [15:0]                  abort_count
`endif
);

    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        enter_resp;
    logic        abort;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] fetch_addr;
    logic [31:0] offset;
    logic [29:0] word_idx;
    logic        in_range;

    // Preload port; the array is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (load_en && !reset) begin
            mem[load_addr] <= load_data;
        end
    end

    // With LATENCY=1 the read happens on the acceptance edge, so the live address is used.
    assign fetch_addr = (state_q == IDLE) ? mem_req_addr : addr_q;
    assign offset     = fetch_addr - BASE_ADDR;
    assign word_idx   = offset[31:2];
    assign in_range   = ((word_idx >> IDX_W) == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ready_d    = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        abort      = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    addr_d = mem_req_addr;
                    cnt_d  = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_req_valid) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            state_d = RESP;
            ready_d = 1'b1;
            if (in_range) begin
                rdata_d = mem[word_idx[IDX_W-1:0]];
            end else begin
                rdata_d = NOP;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req_ready = ready_q;
    assign mem_req_rdata = rdata_q;
    assign addr_err      = err_q;

`ifdef IMEM_STATS_EN
    logic [31:0] req_count_q, req_count_d;
    logic [15:0] abort_count_q, abort_count_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        req_count_d   = req_count_q;
        abort_count_d = abort_count_q;
        if (enter_resp && (req_count_q != '1)) begin
            req_count_d = req_count_q + 32'd1;
        end
        if (abort && (abort_count_q != '1)) begin
            abort_count_d = abort_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_count_q   <= 32'd0;
            abort_count_q <= 16'd0;
        end else begin
            req_count_q   <= req_count_d;
            abort_count_q <= abort_count_d;
        end
    end

    assign req_count   = req_count_q;
    assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (LATENCY 3, 1, 4) share one stimulus stream.
module tb_imem_responder;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        loadEn;
    logic [9:0]  loadAddr;
    logic [31:0] loadData;

    logic        ready3, ready1, ready4;
    logic [31:0] rdata3, rdata1, rdata4;
    logic        err3, err1, err4;
`ifdef IMEM_STATS_EN
    logic [31:0] reqCount3, reqCount1, reqCount4;
    logic [15:0] abortCount3, abortCount1, abortCount4;
`endif

    int checks = 0;
    int errors = 0;

    imem_responder #(.MEM_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u3 (
        .clk(clk), .reset(reset), .mem_req_valid(reqValid), .mem_req_addr(reqAddr),
        .mem_req_ready(ready3), .mem_req_rdata(rdata3), .load_en(loadEn),
        .load_addr(loadAddr), .load_data(loadData), .addr_err(err3)
`ifdef IMEM_STATS_EN
        , .req_count(reqCount3), .abort_count(abortCount3)
`endif
    );

    imem_responder #(.MEM_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u1 (
        .clk(clk), .reset(reset), .mem_req_valid(reqValid), .mem_req_addr(reqAddr),
        .mem_req_ready(ready1), .mem_req_rdata(rdata1), .load_en(loadEn),
        .load_addr(loadAddr), .load_data(loadData), .addr_err(err1)
`ifdef IMEM_STATS_EN
        , .req_count(reqCount1), .abort_count(abortCount1)
`endif
    );

    imem_responder #(.MEM_WORDS(1024), .LATENCY(4), .BASE_ADDR(32'h0)) u4 (
        .clk(clk), .reset(reset), .mem_req_valid(reqValid), .mem_req_addr(reqAddr),
        .mem_req_ready(ready4), .mem_req_rdata(rdata4), .load_en(loadEn),
        .load_addr(loadAddr), .load_data(loadData), .addr_err(err4)
`ifdef IMEM_STATS_EN
        , .req_count(reqCount4), .abort_count(abortCount4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a,
                                 input logic le, input logic [9:0] la, input logic [31:0] ld);
        reqValid = v;
        reqAddr  = a;
        loadEn   = le;
        loadAddr = la;
        loadData = ld;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);

        // Reset must act without any clock edge.
        #1 reset = 1'b1;
        #2;
        checkOutput("reset_ready", {31'b0, ready3}, 32'h0);
        checkOutput("reset_rdata", rdata3, 32'h0);
        checkOutput("reset_err", {31'b0, err3}, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Preload words 3, 5, 8, 9.
        applyStimulus(1'b0, 32'h0, 1'b1, 10'd3, 32'h0000_0000); tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 10'd5, 32'hDEAD_BEEF); tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 10'd8, 32'hA0A0_0008); tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 10'd9, 32'hB0B0_0009); tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
        tick();

        // LATENCY=3 fetch of word 5: pulse only after edge T+3.
        applyStimulus(1'b1, 32'h14, 1'b0, 10'd0, 32'h0);
        tick();
        tick(); checkOutput("lat3_ready_t1", {31'b0, ready3}, 32'h0);
        tick(); checkOutput("lat3_ready_t2", {31'b0, ready3}, 32'h0);
        tick(); checkOutput("lat3_ready_t3", {31'b0, ready3}, 32'h1);
        checkOutput("lat3_rdata", rdata3, 32'hDEAD_BEEF);
        reqValid = 1'b0;
        tick(); checkOutput("lat3_ready_t4", {31'b0, ready3}, 32'h0);
        tick(); tick(); tick();

        // LATENCY=1 two-word line fetch; valid held across RESP must not re-accept.
        applyStimulus(1'b1, 32'h20, 1'b0, 10'd0, 32'h0);
        tick(); checkOutput("lat1_ready_a", {31'b0, ready1}, 32'h1);
        checkOutput("lat1_rdata_a", rdata1, 32'hA0A0_0008);
        tick(); checkOutput("lat1_no_reaccept", {31'b0, ready1}, 32'h0);
        applyStimulus(1'b0, 32'h24, 1'b0, 10'd0, 32'h0);
        tick(); checkOutput("lat1_gap", {31'b0, ready1}, 32'h0);
        reqValid = 1'b1;
        tick(); checkOutput("lat1_ready_b", {31'b0, ready1}, 32'h1);
        checkOutput("lat1_rdata_b", rdata1, 32'hB0B0_0009);
        reqValid = 1'b0;
        tick(); tick(); tick(); tick(); tick();

        // Out-of-range request, then an in-range one: flag stays set.
        applyStimulus(1'b1, 32'h0000_1000, 1'b0, 10'd0, 32'h0);
        tick(); tick(); tick(); tick();
        checkOutput("oor_ready", {31'b0, ready3}, 32'h1);
        checkOutput("oor_rdata", rdata3, 32'h0000_0013);
        checkOutput("oor_err", {31'b0, err3}, 32'h1);
        reqValid = 1'b0;
        tick();
        applyStimulus(1'b1, 32'h14, 1'b0, 10'd0, 32'h0);
        tick(); tick(); tick(); tick();
        checkOutput("inrange_rdata", rdata3, 32'hDEAD_BEEF);
        checkOutput("err_sticky", {31'b0, err3}, 32'h1);
        reqValid = 1'b0;
        tick();

        // Reset in the middle of WAIT clears outputs at once and cancels the request.
        applyStimulus(1'b1, 32'h14, 1'b0, 10'd0, 32'h0);
        tick(); tick();
        reqValid = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("midwait_rst_ready", {31'b0, ready3}, 32'h0);
        checkOutput("midwait_rst_rdata", rdata3, 32'h0);
        checkOutput("midwait_rst_err", {31'b0, err3}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("post_rst_quiet_%0d", i), {31'b0, ready3}, 32'h0);
        end

        // LATENCY=4 abort after two WAIT cycles: no pulse, even where it would have fired.
        applyStimulus(1'b1, 32'h14, 1'b0, 10'd0, 32'h0);
        tick(); tick();
        tick(); checkOutput("abort_t2", {31'b0, ready4}, 32'h0);
        reqValid = 1'b0;
        tick(); checkOutput("abort_t3", {31'b0, ready4}, 32'h0);
        tick(); checkOutput("abort_t4", {31'b0, ready4}, 32'h0);
        tick(); checkOutput("abort_t5", {31'b0, ready4}, 32'h0);
`ifdef IMEM_STATS_EN
        checkOutput("abort_count", {16'b0, abortCount4}, 32'h1);
        checkOutput("req_count", reqCount4, 32'h0);
`endif

        // Preloaded word survives the reset.
        applyStimulus(1'b1, 32'h14, 1'b0, 10'd0, 32'h0);
        tick(); tick(); tick(); tick();
        checkOutput("survive_ready", {31'b0, ready3}, 32'h1);
        checkOutput("survive_rdata", rdata3, 32'hDEAD_BEEF);
        reqValid = 1'b0;
        tick();

        // Load on the RESP-entry edge returns the old word; next fetch sees the new one.
        applyStimulus(1'b1, 32'h0C, 1'b0, 10'd0, 32'h0);
        tick(); tick(); tick();
        applyStimulus(1'b1, 32'h0C, 1'b1, 10'd3, 32'h1234_5678);
        tick();
        checkOutput("rw_same_edge_ready", {31'b0, ready3}, 32'h1);
        checkOutput("rw_same_edge_rdata", rdata3, 32'h0000_0000);
        applyStimulus(1'b0, 32'h0C, 1'b0, 10'd0, 32'h0);
        tick();
        reqValid = 1'b1;
        tick(); tick(); tick(); tick();
        checkOutput("rw_next_ready", {31'b0, ready3}, 32'h1);
        checkOutput("rw_next_rdata", rdata3, 32'h1234_5678);
        reqValid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
